rx_fifo_param: RTL and testbench

- Parametrised receive FIFO: the next generation of the fixed 8-bit receive FIFO.
- Single clock domain; configurable data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between the receive data path (writer) and the protocol/packet controller (reader).

---
 rtl/rx_fifo_param.sv | 113 +++++++++++
 tb/tb_rx_fifo_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_param.sv
`default_nettype none
// ============================================================================
// rx_fifo_param : parametrised show-ahead receive FIFO with occupancy count,
//                 threshold flags and sticky overflow/underflow errors.
//                 Optional synchronous flush port: define RX_FIFO_FLUSH_EN.
// Revision      : 1.0
// ============================================================================
module rx_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    w_enable,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    r_enable,
`ifdef RX_FIFO_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    err_clear,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  flush_now;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ovf_set;
    logic                  unf_set;

`ifdef RX_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // A flush swallows both requests, so neither can be accepted nor flagged.
    assign rd_ok   = r_enable && !empty && !flush_now;
    assign wr_ok   = w_enable && (!full || rd_ok) && !flush_now;
    assign ovf_set = w_enable && !wr_ok && !flush_now;
    assign unf_set = r_enable && !rd_ok && !flush_now;

    assign empty        = (count == '0);
    assign full         = (count == CNT_FULL);
    assign almost_full  = (count >= CNT_AFULL);
    assign almost_empty = (count <= CNT_AEMPTY);
    assign r_data       = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // err_clear takes priority over an error raised in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo_param.sv
`default_nettype none
// Randomised and directed bench for rx_fifo_param against a queue-based model.
module tb_rx_fifo_param;

    localparam int DEPTH = 8;
`ifdef RX_FIFO_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       w_enable = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_enable = 1'b0;
    logic       flush = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] r_data;
    logic       empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    rx_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .w_enable(w_enable),
        .w_data(w_data),
        .r_enable(r_enable),
`ifdef RX_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .err_clear(err_clear),
        .r_data(r_data),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue limited to DEPTH entries by rule.
    always @(posedge clk or negedge n_rst) begin
        int  sz;
        bit  rdok, wrok;
        if (!n_rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (HAS_FLUSH && flush) begin
            q.delete();
            if (err_clear) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            sz   = q.size();
            rdok = r_enable && (sz != 0);
            wrok = w_enable && ((sz != DEPTH) || rdok);
            if (err_clear) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (w_enable && !wrok) m_ovf = 1'b1;
                if (r_enable && !rdok) m_unf = 1'b1;
            end
            if (rdok) void'(q.pop_front());
            if (wrok) q.push_back(w_data);
        end
    end

    always @(negedge clk) begin
        int         sz;
        logic [7:0] head;
        if (chk_en) begin
            sz   = q.size();
            head = (sz != 0) ? q[0] : 8'h00;
            chk("count", count, sz);
            chk("empty", empty, sz == 0);
            chk("full", full, sz == DEPTH);
            chk("almost_full", almost_full, sz >= 6);
            chk("almost_empty", almost_empty, sz <= 1);
            chk("r_data", r_data, head);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
        end
    end

    task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit ec, input bit fl);
        w_enable  = we;
        w_data    = wd;
        r_enable  = re;
        err_clear = ec;
        flush     = fl & HAS_FLUSH;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        w_enable  = 1'b0;
        r_enable  = 1'b0;
        err_clear = 1'b0;
        flush     = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_r_data", r_data, 0);
        @(posedge clk);
        @(negedge clk);
        #2 n_rst = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_seq[8];
        #1 n_rst = 1'b0;
        #1;
        chk("init_count", count, 0);
        chk("init_empty", empty, 1);
        chk("init_full", full, 0);
        chk("init_aempty", almost_empty, 1);
        chk("init_afull", almost_full, 0);
        chk("init_ovf", overflow, 0);
        chk("init_unf", underflow, 0);
        chk("init_r_data", r_data, 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        chk_en = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            chk("fill_count", count, i);
            chk("fill_afull", almost_full, i >= 6);
            chk("fill_full", full, i == 8);
            chk("fill_r_data", r_data, 8'h01);
        end
        cyc(1, 8'h09, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_r_data", r_data, i);
            cyc(0, 8'h00, 1, 0, 0);
        end
        chk("drain_empty", empty, 1);
        cyc(0, 8'h00, 1, 0, 0);
        chk("unf_set", underflow, 1);
        chk("unf_r_data", r_data, 0);
        chk("unf_count", count, 0);
        cyc(0, 8'h00, 0, 1, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);

        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'hAA, 1, 0, 0);
        chk("fullrw_count", count, 8);
        chk("fullrw_ovf", overflow, 0);
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            chk("wrap_r_data", r_data, exp_seq[i]);
            cyc(0, 8'h00, 1, 0, 0);
        end

        cyc(1, 8'h55, 1, 0, 0);
        chk("emptyrw_count", count, 1);
        chk("emptyrw_unf", underflow, 1);
        chk("emptyrw_r_data", r_data, 8'h55);
        cyc(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
        chk("prerst_count", count, 5);
        pulse_reset();

`ifdef RX_FIFO_FLUSH_EN
        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'h77, 0, 0, 1);
        chk("flush_count", count, 0);
        chk("flush_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(1, 8'h11, 1, 0, 1);
        chk("flushfull_count", count, 0);
        chk("flushfull_ovf", overflow, 0);
        chk("flushfull_unf", underflow, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            int wbias;
            wbias = ((n / 150) % 2 == 0) ? 75 : 30;
            if (n == 1000 || n == 2000) pulse_reset();
            cyc(($urandom_range(0, 99) < wbias), 8'($urandom),
                ($urandom_range(0, 99) < (105 - wbias)),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
